input_handshake_unit: RTL and testbench

- Board-side responder for the IN-instruction wait protocol.
- While the control unit holds the PC in the input-wait code (muxPC = 5), the PC advances by processIn each cycle; this block generates that processIn.
- The operator sets the switches and presses a confirm key. The block debounces the key, latches the switch value onto the datapath input bus, and pulses process_in for exactly one cycle.
- Sits between the board I/O pins, the control unit and the PC/register-file write path.

---
 rtl/input_handshake_pkg.sv | 15 +
 rtl/input_debouncer.sv | 48 ++++
 rtl/input_handshake_unit.sv | 101 ++++++++++
 tb/tb_input_handshake_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/input_handshake_pkg.sv
// Shared definitions for the IN-instruction operator handshake: FSM state
// encoding and the control-unit PC-mux code that marks the input-wait state.
package input_handshake_pkg;

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] WAIT_RELEASE = 2'd1;
  localparam logic [1:0] WAIT_PRESS   = 2'd2;
  localparam logic [1:0] ACK          = 2'd3;

  // PC-mux select the control unit drives while it waits for processIn.
  localparam logic [3:0] MUXPC_WAIT_IN = 4'd5;

  localparam int IN_DATA_WIDTH = 32;

endpackage

// File: rtl/input_debouncer.sv
// Synchronizes and debounces one raw asynchronous key; level is 1 while the
// key is considered pressed, regardless of the key's electrical polarity.
module input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                   normalized;
  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   synced;
  logic [CNT_W-1:0]       count;

  // Polarity is folded in ahead of the chain so a cleared chain reads as released.
  assign normalized = raw ^ ACTIVE_LOW;
  assign synced     = sync_chain[SYNC_STAGES-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_chain <= '0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], normalized};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      level <= 1'b0;
      count <= '0;
    end else if (synced == level) begin
      count <= '0;
    end else if (count == CNT_LAST) begin
      level <= synced;
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/input_handshake_unit.sv
// Operator handshake for the IN instruction: debounced confirm key, switch
// capture onto in_data and a one-cycle process_in strobe to the PC.
// Define INPUT_SIGN_EXT_EN to sign-extend the captured switches (default: zero-extend).
module input_handshake_unit
  import input_handshake_pkg::*;
#(
  parameter int DATA_WIDTH      = 16,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_request,
  input  logic [DATA_WIDTH-1:0]    switches,
  input  logic                     confirm_btn,
  output logic [IN_DATA_WIDTH-1:0] in_data,
  output logic                     process_in,
  output logic                     waiting
);

  function automatic logic [IN_DATA_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] value);
`ifdef INPUT_SIGN_EXT_EN
    logic signed [DATA_WIDTH-1:0] signed_value;
    signed_value = value;
    return IN_DATA_WIDTH'(signed_value);
`else
    return IN_DATA_WIDTH'(value);
`endif
  endfunction

  logic                  pressed;
  logic [DATA_WIDTH-1:0] sw_sync [SYNC_STAGES];
  logic [1:0]            state;
  logic [1:0]            state_next;

  input_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES),
    .ACTIVE_LOW      (BTN_ACTIVE_LOW)
  ) u_confirm_debouncer (
    .clock (clock),
    .reset (reset),
    .raw   (confirm_btn),
    .level (pressed)
  );

  // Switch synchronizer stages
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sw_sync[i] <= '0;
      end
    end else begin
      sw_sync[0] <= switches;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sw_sync[i] <= sw_sync[i-1];
      end
    end
  end

  // A release must be seen before a press counts, so a held key never re-confirms.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_request) state_next = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (!pressed) state_next = in_request ? WAIT_PRESS : IDLE;
      end
      WAIT_PRESS: begin
        if (!in_request)  state_next = IDLE;
        else if (pressed) state_next = ACK;
      end
      ACK: begin
        state_next = WAIT_RELEASE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      process_in <= 1'b0;
      in_data    <= '0;
    end else begin
      state      <= state_next;
      process_in <= (state_next == ACK);
      if (state == WAIT_PRESS && state_next == ACK) begin
        in_data <= extend(sw_sync[SYNC_STAGES-1]);
      end
    end
  end

  assign waiting = in_request && (state == WAIT_RELEASE || state == WAIT_PRESS);

endmodule

// File: tb/tb_input_handshake_unit.sv
// Directed and randomized bench for input_handshake_unit with a cycle-level
// behavioural model of the synchronizers, debounce window and handshake.
module tb_input_handshake_unit;

  localparam int DW = 16;
  localparam int DB = 4;
  localparam int SS = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_request;
  logic [DW-1:0] switches;
  logic          confirm_btn;
  logic [31:0]   in_data;
  logic          process_in;
  logic          waiting;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int pulses = 0;
  int first_pulse = -1;
  int press_cyc   = 0;

  // Model state
  bit          m_key_sync [SS];
  logic [15:0] m_sw_sync  [SS];
  bit          m_hist [$];
  bit          m_db;
  bit          m_engaged;
  bit          m_armed;
  bit          m_pulse;
  logic [31:0] m_data;

  input_handshake_unit #(
    .DATA_WIDTH      (DW),
    .DEBOUNCE_CYCLES (DB),
    .SYNC_STAGES     (SS),
    .BTN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in_request  (in_request),
    .switches    (switches),
    .confirm_btn (confirm_btn),
    .in_data     (in_data),
    .process_in  (process_in),
    .waiting     (waiting)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] ext(input logic [15:0] v);
`ifdef INPUT_SIGN_EXT_EN
    return {{16{v[15]}}, v};
`else
    return {16'h0000, v};
`endif
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Applies one clock edge to the model using the inputs present at that edge.
  task automatic model_edge();
    bit key_s;
    bit nxt_pulse;
    bit all_differ;
    logic [15:0] sw_s;
    if (reset) begin
      foreach (m_key_sync[i]) m_key_sync[i] = 1'b0;
      foreach (m_sw_sync[i])  m_sw_sync[i]  = '0;
      m_hist.delete();
      m_db = 0; m_engaged = 0; m_armed = 0; m_pulse = 0; m_data = '0;
    end else begin
      key_s = m_key_sync[SS-1];
      sw_s  = m_sw_sync[SS-1];
      nxt_pulse = 1'b0;
      if (m_pulse) begin
        m_armed = 1'b0;
      end else if (!m_engaged) begin
        if (in_request) begin m_engaged = 1'b1; m_armed = 1'b0; end
      end else if (!m_armed) begin
        if (!m_db) begin
          if (in_request) m_armed = 1'b1;
          else m_engaged = 1'b0;
        end
      end else begin
        if (!in_request) begin
          m_engaged = 1'b0; m_armed = 1'b0;
        end else if (m_db) begin
          nxt_pulse = 1'b1;
          m_data = ext(sw_s);
        end
      end
      m_pulse = nxt_pulse;
      // Debounced level flips once the last DB synchronized samples all disagree with it.
      m_hist.push_back(key_s);
      if (m_hist.size() > DB) void'(m_hist.pop_front());
      all_differ = (m_hist.size() == DB);
      foreach (m_hist[i]) if (m_hist[i] == m_db) all_differ = 1'b0;
      if (all_differ) m_db = !m_db;
      for (int i = SS-1; i > 0; i--) begin
        m_key_sync[i] = m_key_sync[i-1];
        m_sw_sync[i]  = m_sw_sync[i-1];
      end
      m_key_sync[0] = !confirm_btn;
      m_sw_sync[0]  = switches;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    cyc++;
    check_bit("process_in", process_in, m_pulse);
    check_word("in_data", in_data, m_data);
    check_bit("waiting", waiting, m_engaged && !m_pulse && in_request);
    if (process_in) begin
      pulses++;
      if (first_pulse < 0) first_pulse = cyc;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic rel(input int n);
    confirm_btn = 1'b1;
    run(n);
  endtask

  task automatic prs(input int n);
    confirm_btn = 1'b0;
    press_cyc   = cyc;
    first_pulse = -1;
    run(n);
  endtask

  initial begin
    int req_left;
    int key_left;
    int k;
    reset = 1'b1; in_request = 1'b0; switches = '0; confirm_btn = 1'b1;
    m_data = '0;
    run(2);
    reset = 1'b0;
    check_word("reset_in_data", in_data, 32'h0);
    check_bit("reset_process_in", process_in, 1'b0);
    check_bit("reset_waiting", waiting, 1'b0);

    // Basic capture
    in_request = 1'b1; switches = 16'h00A5;
    rel(4);
    check_bit("basic_waiting", waiting, 1'b1);
    pulses = 0;
    prs(12);
    check_word("basic_pulses", 32'(pulses), 32'd1);
    check_bit("basic_latency", first_pulse >= 0 && (first_pulse - press_cyc) <= 8, 1'b1);
    check_word("basic_data", in_data, 32'h0000_00A5);
    rel(8);
    in_request = 1'b0;
    run(1);
    check_bit("basic_waiting_fall", waiting, 1'b0);

    // Glitch rejection from a clean reset
    reset = 1'b1; run(2); reset = 1'b0;
    in_request = 1'b1;
    rel(6);
    pulses = 0;
    prs(2);
    rel(10);
    check_word("glitch_pulses", 32'(pulses), 32'd0);
    check_bit("glitch_waiting", waiting, 1'b1);
    check_word("glitch_data", in_data, 32'h0);

    // Key held from before the request
    in_request = 1'b0; switches = 16'h1234;
    prs(10);
    pulses = 0;
    in_request = 1'b1;
    run(20);
    check_word("preheld_no_pulse", 32'(pulses), 32'd0);
    rel(8);
    prs(12);
    check_word("preheld_one_pulse", 32'(pulses), 32'd1);
    check_word("preheld_data", in_data, 32'h0000_1234);

    // Back-to-back IN with a long hold
    rel(8);
    pulses = 0;
    prs(40);
    check_word("b2b_long_hold", 32'(pulses), 32'd1);
    switches = 16'h0003;
    rel(8);
    prs(12);
    check_word("b2b_second", 32'(pulses), 32'd2);
    check_word("b2b_data", in_data, 32'h0000_0003);

    // Abort from WAIT_PRESS
    rel(8);
    pulses = 0;
    in_request = 1'b0;
    prs(12);
    check_word("abort_pulses", 32'(pulses), 32'd0);
    check_bit("abort_waiting", waiting, 1'b0);
    check_word("abort_data_held", in_data, 32'h0000_0003);

    // Reset landing on the ACK cycle
    in_request = 1'b1;
    rel(8);
    confirm_btn = 1'b0;
    k = 0;
    while (!process_in && k < 20) begin tick(); k++; end
    check_bit("ack_seen", process_in, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_bit("ack_reset_pulse", process_in, 1'b0);
    check_word("ack_reset_data", in_data, 32'h0);

    // Extension of a negative switch value
    switches = 16'h8001;
    rel(8);
    prs(12);
`ifdef INPUT_SIGN_EXT_EN
    check_word("ext_data", in_data, 32'hFFFF_8001);
`else
    check_word("ext_data", in_data, 32'h0000_8001);
`endif
    rel(8);

    // Randomized traffic against the model
    req_left = 0; key_left = 0;
    for (int i = 0; i < 2000; i++) begin
      if (req_left == 0) begin
        in_request = ($urandom_range(3, 0) != 0);
        req_left = $urandom_range(60, 10);
      end else begin
        req_left--;
      end
      if (key_left == 0) begin
        confirm_btn = $urandom_range(1, 0) == 1;
        key_left = $urandom_range(10, 1);
      end else begin
        key_left--;
      end
      if ($urandom_range(7, 0) == 0) switches = 16'($urandom);
      reset = ($urandom_range(399, 0) == 0);
      tick();
    end
    reset = 1'b0;
    run(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
